// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic array computing C = A*B: A streams rightward, B streams downward,
// and each PE(i,j) accumulates its own C element in place.
module systolic_matmul_engine #(
    parameter int M         = 2,
    parameter int K         = 2,
    parameter int N         = 2,
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int SIGNED    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       start_ready,
    input  logic [M*K*OP_WIDTH-1:0]    a,
    input  logic [K*N*OP_WIDTH-1:0]    b,
    output logic                       busy,
    output logic [M*N*ACC_WIDTH-1:0]   c,
    output logic                       c_valid,
    input  logic                       c_ready
);

    localparam int STEPS  = M + N + K - 2;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW     = 2 * OP_WIDTH;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic                    w_accept;
    logic [M*K*OP_WIDTH-1:0] r_a;
    logic [K*N*OP_WIDTH-1:0] r_b;
    logic [STEP_W-1:0]       r_step;

    logic [OP_WIDTH-1:0]  w_aFeed [M];
    logic [OP_WIDTH-1:0]  w_bFeed [N];
    logic [OP_WIDTH-1:0]  w_aIn   [M][N];
    logic [OP_WIDTH-1:0]  w_bIn   [M][N];
    logic [OP_WIDTH-1:0]  r_aPipe [M][N];
    logic [OP_WIDTH-1:0]  r_bPipe [M][N];
    logic [ACC_WIDTH-1:0] r_acc   [M][N];

    // Full-width product, then sign- or zero-extended into the accumulator width.
    function automatic logic [ACC_WIDTH-1:0] mulExt(input logic [OP_WIDTH-1:0] x,
                                                     input logic [OP_WIDTH-1:0] y);
        logic [PW-1:0] xe;
        logic [PW-1:0] ye;
        logic [PW-1:0] p;
        if (SIGNED != 0) begin
            xe = PW'($signed(x));
            ye = PW'($signed(y));
            p  = xe * ye;
            mulExt = ACC_WIDTH'($signed(p));
        end else begin
            xe = PW'(x);
            ye = PW'(y);
            p  = xe * ye;
            mulExt = ACC_WIDTH'(p);
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        start_ready = 1'b0;
        busy        = 1'b1;
        c_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start) begin
                    w_accept    = 1'b1;
                    w_stateNext = COMPUTE;
                end
            end
            COMPUTE: begin
                if (r_step == LAST_STEP) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                c_valid = 1'b1;
                if (c_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Skewed edge feeds: row i lags by i steps and column j by j steps, so matching k meet in PE(i,j).
    always_comb begin
        int idx;
        idx = 0;
        for (int i = 0; i < M; i++) begin
            w_aFeed[i] = '0;
            idx = int'(r_step) - i;
            if (idx >= 0 && idx < K) begin
                w_aFeed[i] = r_a[OP_WIDTH*(i*K+idx) +: OP_WIDTH];
            end
        end
        for (int j = 0; j < N; j++) begin
            w_bFeed[j] = '0;
            idx = int'(r_step) - j;
            if (idx >= 0 && idx < K) begin
                w_bFeed[j] = r_b[OP_WIDTH*(idx*N+j) +: OP_WIDTH];
            end
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_aEdge
                assign w_aIn[gi][gj] = w_aFeed[gi];
            end else begin : g_aInner
                assign w_aIn[gi][gj] = r_aPipe[gi][gj-1];
            end
            if (gi == 0) begin : g_bEdge
                assign w_bIn[gi][gj] = w_bFeed[gj];
            end else begin : g_bInner
                assign w_bIn[gi][gj] = r_bPipe[gi-1][gj];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_step <= '0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_aPipe[i][j] <= '0;
                    r_bPipe[i][j] <= '0;
                    r_acc[i][j]   <= '0;
                end
            end
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_step <= '0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_aPipe[i][j] <= '0;
                    r_bPipe[i][j] <= '0;
                    r_acc[i][j]   <= '0;
                end
            end
        end else if (r_state == COMPUTE) begin
            r_step <= (r_step == LAST_STEP) ? '0 : r_step + 1'b1;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_aPipe[i][j] <= w_aIn[i][j];
                    r_bPipe[i][j] <= w_bIn[i][j];
                    r_acc[i][j]   <= r_acc[i][j] + mulExt(w_aIn[i][j], w_bIn[i][j]);
                end
            end
        end
    end

    always_comb begin
        c = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                c[ACC_WIDTH*(i*N+j) +: ACC_WIDTH] = r_acc[i][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Bench for systolic_matmul_engine: a transaction-level model checks a 2x3x4 instance every
// cycle; three small instances pin the 2x2 identity, signed 1x1 and 16-bit wrap cases.
module tb_systolic_matmul_engine;

    localparam int LMAIN = 2 + 4 + 3 - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cReady;
    logic [47:0]  aIn;
    logic [95:0]  bIn;
    logic [255:0] cOut;
    logic         cValid;
    logic         busy;
    logic         startReady;

    logic         smallStart;
    logic [127:0] sqC;
    logic         sqValid, sqBusy, sqReady;
    logic [31:0]  sigC;
    logic         sigValid, sigBusy, sigReady;
    logic [15:0]  wrapC;
    logic         wrapValid, wrapBusy, wrapReady;

    int vecCount  = 0;
    int missCount = 0;
    bit checkEn   = 1'b0;

    // Model state: a run is either in flight (counting down to its result) or held for the consumer.
    bit           mInFlight = 1'b0;
    bit           mHeld     = 1'b0;
    int           mCount    = 0;
    int           mDoneCount = 0;
    logic [255:0] mExpC     = '0;
    logic [255:0] mPending  = '0;

    systolic_matmul_engine #(.M(2), .K(3), .N(4), .OP_WIDTH(8), .ACC_WIDTH(32), .SIGNED(0)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ready(startReady),
        .a(aIn), .b(bIn), .busy(busy), .c(cOut), .c_valid(cValid), .c_ready(cReady)
    );

    systolic_matmul_engine #(.M(2), .K(2), .N(2), .OP_WIDTH(8), .ACC_WIDTH(32), .SIGNED(0)) dutSq (
        .clk(clk), .reset(reset), .start(smallStart), .start_ready(sqReady),
        .a(32'h01000001), .b(32'h04030201), .busy(sqBusy), .c(sqC), .c_valid(sqValid), .c_ready(1'b1)
    );

    systolic_matmul_engine #(.M(1), .K(1), .N(1), .OP_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1)) dutSig (
        .clk(clk), .reset(reset), .start(smallStart), .start_ready(sigReady),
        .a(8'h80), .b(8'h7F), .busy(sigBusy), .c(sigC), .c_valid(sigValid), .c_ready(1'b1)
    );

    systolic_matmul_engine #(.M(1), .K(2), .N(1), .OP_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0)) dutWrap (
        .clk(clk), .reset(reset), .start(smallStart), .start_ready(wrapReady),
        .a(16'hFFFF), .b(16'hFFFF), .busy(wrapBusy), .c(wrapC), .c_valid(wrapValid), .c_ready(1'b1)
    );

    always #5 clk = ~clk;

    // Plain row-by-column matrix product, truncated to 32 bits per element.
    function automatic logic [255:0] golden(input logic [47:0] av, input logic [95:0] bv);
        logic [255:0] r;
        logic [31:0]  sum;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                sum = '0;
                for (int k = 0; k < 3; k++) begin
                    sum = sum + 32'(av[8*(i*3+k) +: 8]) * 32'(bv[8*(k*4+j) +: 8]);
                end
                r[32*(i*4+j) +: 32] = sum;
            end
        end
        return r;
    endfunction

    function automatic logic [47:0] randA();
        return 48'({$urandom(), $urandom()});
    endfunction

    function automatic logic [95:0] randB();
        return 96'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit cr, input logic [47:0] av, input logic [95:0] bv);
        @(negedge clk);
        start  = st;
        cReady = cr;
        aIn    = av;
        bIn    = bv;
    endtask

    // Launches one run and returns the number of rising edges, accept edge included, until c_valid.
    task automatic runMain(input logic [47:0] av, input logic [95:0] bv, output int lat);
        applyStimulus(1'b1, 1'b1, av, bv);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!cValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Model advances on the same edge as the design, using only the inputs the bench drives.
    always @(posedge clk) begin
        if (reset) begin
            mInFlight = 1'b0;
            mHeld     = 1'b0;
            mExpC     = '0;
        end else if (mHeld) begin
            if (cReady) mHeld = 1'b0;
        end else if (mInFlight) begin
            mCount--;
            if (mCount == 0) begin
                mInFlight = 1'b0;
                mHeld     = 1'b1;
                mExpC     = mPending;
                mDoneCount++;
            end
        end else if (start) begin
            mPending  = golden(aIn, bIn);
            mInFlight = 1'b1;
            mCount    = LMAIN - 1;
        end
    end

    // Every cycle: handshake outputs always, and c whenever no run is in flight.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("start_ready", 256'(startReady), 256'(!mInFlight && !mHeld));
            checkOutput("busy", 256'(busy), 256'(mInFlight || mHeld));
            checkOutput("c_valid", 256'(cValid), 256'(mHeld));
            if (!mInFlight) checkOutput("c", cOut, mExpC);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int firstSq, cntSq, firstSig, firstWrap, dutRuns, base, n;
        reset = 1'b1; start = 1'b0; cReady = 1'b0; aIn = '0; bIn = '0; smallStart = 1'b0;
        @(negedge clk);
        checkEn = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_c", cOut, '0);
        checkOutput("reset_start_ready", 256'(startReady), 256'(1));

        // Small instances launched together; each must hit its own latency and literal result.
        @(negedge clk);
        smallStart = 1'b1;
        @(negedge clk);
        smallStart = 1'b0;
        firstSq = 0; cntSq = 0; firstSig = 0; firstWrap = 0;
        for (int e = 1; e <= 10; e++) begin
            if (e > 1) @(negedge clk);
            if (sqValid) begin
                cntSq++;
                if (firstSq == 0) firstSq = e;
            end
            if (sigValid && firstSig == 0) firstSig = e;
            if (wrapValid && firstWrap == 0) firstWrap = e;
        end
        checkOutput("sq_latency", 256'(firstSq), 256'(5));
        checkOutput("sq_valid_cycles", 256'(cntSq), 256'(1));
        checkOutput("sq_c", 256'(sqC), 256'({32'd4, 32'd3, 32'd2, 32'd1}));
        checkOutput("signed_latency", 256'(firstSig), 256'(2));
        checkOutput("signed_c", 256'(sigC), 256'(32'hFFFFC080));
        checkOutput("wrap_latency", 256'(firstWrap), 256'(3));
        checkOutput("wrap_c", 256'(wrapC), 256'(16'd64514));
        checkOutput("small_idle_ready", 256'({sqReady, sigReady, wrapReady}), 256'(3'b111));
        checkOutput("small_idle_busy", 256'({sqBusy, sigBusy, wrapBusy}), 256'(3'b000));

        // Selector rows of A pick rows 0 and 1 of B (values 1..12 in element order).
        runMain(48'h00_01_00_00_00_01, 96'h0c0b0a09_08070605_04030201, lat);
        checkOutput("lit1_latency", 256'(lat), 256'(8));
        for (int e = 0; e < 8; e++) begin
            checkOutput($sformatf("lit1_c%0d", e), 256'(cOut[32*e +: 32]), 256'(e + 1));
        end

        // A=[[1,2,3],[4,5,6]], B all ones: row sums 6 and 15.
        runMain(48'h06_05_04_03_02_01, {12{8'h01}}, lat);
        for (int e = 0; e < 8; e++) begin
            checkOutput($sformatf("lit2_c%0d", e), 256'(cOut[32*e +: 32]), 256'((e < 4) ? 6 : 15));
        end

        // Back-to-back random runs with operands changing every cycle.
        base = mDoneCount;
        dutRuns = 0;
        for (int cyc = 0; cyc < 2000 && (mDoneCount - base) < 100; cyc++) begin
            applyStimulus(1'b1, 1'b1, randA(), randB());
            if (cValid) dutRuns++;
        end
        applyStimulus(1'b0, 1'b1, randA(), randB());
        checkOutput("b2b_runs", 256'(dutRuns), 256'(100));

        // Consumer stall with start pulses and changing operands, then joint start+c_ready release.
        applyStimulus(1'b1, 1'b0, randA(), randB());
        applyStimulus(1'b0, 1'b0, randA(), randB());
        n = 0;
        while (!cValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_reached_done", 256'(cValid), 256'(1));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i % 2 == 0, 1'b0, randA(), randB());
        end
        checkOutput("stall_start_ready", 256'(startReady), 256'(0));
        applyStimulus(1'b1, 1'b1, randA(), randB());
        applyStimulus(1'b0, 1'b0, randA(), randB());
        checkOutput("release_start_ready", 256'(startReady), 256'(1));
        checkOutput("release_c_valid", 256'(cValid), 256'(0));
        applyStimulus(1'b0, 1'b0, randA(), randB());
        checkOutput("release_no_run", 256'(busy), 256'(0));

        // Reset in the middle of a run discards it; the next run is clean.
        applyStimulus(1'b1, 1'b1, randA(), randB());
        applyStimulus(1'b0, 1'b1, randA(), randB());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_c", cOut, '0);
        checkOutput("midreset_c_valid", 256'(cValid), 256'(0));
        checkOutput("midreset_start_ready", 256'(startReady), 256'(1));
        reset = 1'b0;
        runMain(48'h00_01_00_00_00_01, 96'h0c0b0a09_08070605_04030201, lat);
        checkOutput("post_reset_latency", 256'(lat), 256'(8));
        for (int e = 0; e < 8; e++) begin
            checkOutput($sformatf("post_reset_c%0d", e), 256'(cOut[32*e +: 32]), 256'(e + 1));
        end
        applyStimulus(1'b0, 1'b1, '0, '0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
